core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer_pkg.sv | 67 ++++++
 rtl/core_sequencer_decoder.sv | 47 ++++
 rtl/core_sequencer.sv | 158 +++++++++++++++
 tb/tb_core_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the RV32I control sequencer.
// FSM states, instruction classes, opcodes and control-word layout.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH,
    WAIT_I,
    DECODE,
    MEM,
    WAIT_D,
    WB,
    HALT
  } state_t;

  localparam logic [3:0] IT_LOAD   = 4'd0;
  localparam logic [3:0] IT_IMM    = 4'd1;
  localparam logic [3:0] IT_STORE  = 4'd2;
  localparam logic [3:0] IT_REG    = 4'd3;
  localparam logic [3:0] IT_LUI    = 4'd4;
  localparam logic [3:0] IT_AUIPC  = 4'd5;
  localparam logic [3:0] IT_BRANCH = 4'd6;
  localparam logic [3:0] IT_JALR   = 4'd7;
  localparam logic [3:0] IT_JAL    = 4'd8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CW_W        = 23;
  localparam int CW_TYPE_LSB = 0;
  localparam int CW_FUN3_LSB = 4;
  localparam int CW_RD_LSB   = 7;
  localparam int CW_RS1_LSB  = 12;
  localparam int CW_RS2_LSB  = 17;
  localparam int CW_F7B5     = 22;

  // Packed in the same order as the field positions above.
  typedef struct packed {
    logic       f7b5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic [2:0] fun3;
    logic [3:0] itype;
  } cword_t;

  // A register write happens unless the class has no rd or rd is x0.
  function automatic logic rf_write(input cword_t cw);
    return (cw.itype != IT_STORE) &&
           (cw.itype != IT_BRANCH) &&
           (cw.rd != 5'd0);
  endfunction

endpackage

// File: rtl/core_sequencer_decoder.sv
// Combinational RV32I opcode classifier and field splitter.
// Produces the control word and a legal-opcode flag.
module rv32i_decoder
  import core_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output cword_t      cw
);

  logic [6:0] op;
  logic [3:0] ity;
  logic       unused_bits;

  assign op = instr[6:0];
  assign unused_bits = ^{instr[31], instr[29:25]};

  // Map the major opcode onto an instruction class.
  always_comb begin
    legal = 1'b1;
    ity   = IT_LOAD;
    unique case (1'b1)
      (op == OP_LOAD):   ity = IT_LOAD;
      (op == OP_IMM):    ity = IT_IMM;
      (op == OP_STORE):  ity = IT_STORE;
      (op == OP_REG):    ity = IT_REG;
      (op == OP_LUI):    ity = IT_LUI;
      (op == OP_AUIPC):  ity = IT_AUIPC;
      (op == OP_BRANCH): ity = IT_BRANCH;
      (op == OP_JALR):   ity = IT_JALR;
      (op == OP_JAL):    ity = IT_JAL;
      default:           legal = 1'b0;
    endcase
  end

  // Raw instruction fields feed the control word unchanged.
  always_comb begin
    cw       = '0;
    cw.itype = ity;
    cw.fun3  = instr[14:12];
    cw.rd    = instr[11:7];
    cw.rs1   = instr[19:15];
    cw.rs2   = instr[24:20];
    cw.f7b5  = instr[30];
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, memory, writeback.
// All strobes and request valids are registered FSM outputs.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  input  logic            dmem_rsp_valid,
  output logic [CW_W-1:0] cword,
  output logic            pc_we,
  output logic            rf_we,
  output logic            illegal,
  output logic            timeout,
  output logic [31:0]     instret
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] ir;
  logic [TW-1:0] tcnt;
  cword_t      cw_q;
  cword_t      dec_cw;
  logic        dec_legal;
  logic        tmo;

  assign cword = cw_q;
  assign tmo   = (tcnt == TLAST);

  rv32i_decoder u_dec (
    .instr (ir),
    .legal (dec_legal),
    .cw    (dec_cw)
  );

  // Sequencer FSM with registered strobes, valids and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      ir             <= '0;
      tcnt           <= '0;
      cw_q           <= '0;
      pc_we          <= 1'b0;
      rf_we          <= 1'b0;
      imem_req_valid <= 1'b0;
      dmem_req_valid <= 1'b0;
      illegal        <= 1'b0;
      timeout        <= 1'b0;
      instret        <= '0;
    end else begin
      pc_we <= 1'b0;
      rf_we <= 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            tcnt           <= '0;
            state          <= WAIT_I;
          end else if (tmo) begin
            imem_req_valid <= 1'b0;
            timeout        <= 1'b1;
            state          <= HALT;
          end else begin
            imem_req_valid <= 1'b1;
            tcnt           <= tcnt + 1'b1;
          end
        end
        WAIT_I: begin
          if (imem_rsp_valid) begin
            ir    <= imem_rsp_data;
            tcnt  <= '0;
            state <= DECODE;
          end else if (tmo) begin
            timeout <= 1'b1;
            state   <= HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DECODE: begin
          tcnt <= '0;
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            cw_q <= dec_cw;
            if (dec_cw.itype == IT_LOAD ||
                dec_cw.itype == IT_STORE) begin
              dmem_req_valid <= 1'b1;
              state          <= MEM;
            end else begin
              pc_we <= 1'b1;
              rf_we <= rf_write(dec_cw);
              state <= WB;
            end
          end
        end
        MEM: begin
          if (dmem_req_valid && dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            tcnt           <= '0;
            if (cw_q.itype == IT_STORE) begin
              pc_we <= 1'b1;
              rf_we <= rf_write(cw_q);
              state <= WB;
            end else begin
              state <= WAIT_D;
            end
          end else if (tmo) begin
            dmem_req_valid <= 1'b0;
            timeout        <= 1'b1;
            state          <= HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_D: begin
          if (dmem_rsp_valid) begin
            tcnt  <= '0;
            pc_we <= 1'b1;
            rf_we <= rf_write(cw_q);
            state <= WB;
          end else if (tmo) begin
            timeout <= 1'b1;
            state   <= HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WB: begin
          instret        <= instret + 32'd1;
          tcnt           <= '0;
          imem_req_valid <= 1'b1;
          state          <= FETCH;
        end
        HALT: begin
          imem_req_valid <= 1'b0;
          dmem_req_valid <= 1'b0;
        end
        default: begin
          imem_req_valid <= 1'b0;
          dmem_req_valid <= 1'b0;
          state          <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer.
// Expected retirements are queued at fetch and checked on pc_we.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_rsp_valid;
  logic [22:0] cword;
  logic        pc_we;
  logic        rf_we;
  logic        illegal;
  logic        timeout;
  logic [31:0] instret;

  typedef struct {
    logic [22:0] cw;
    logic        rf;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          errs;
  int          checks;
  logic [31:0] exp_ret;
  logic [22:0] last_cw;

  core_sequencer #(.TIMEOUT(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .cword          (cword),
    .pc_we          (pc_we),
    .rf_we          (rf_we),
    .illegal        (illegal),
    .timeout        (timeout),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [22:0] mk_cw(input logic [31:0] i,
                                        input logic [3:0] t);
    return {i[30], i[24:20], i[19:15], i[11:7], i[14:12], t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!imem_req_valid && n < 50) begin
      step();
      n++;
    end
    chk("fetch_valid", imem_req_valid, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq", imem_req_valid, 0);
    chk("rst_dreq", dmem_req_valid, 0);
    chk("rst_pcwe", pc_we, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_cword", cword, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_instret", instret, 0);
    sb.delete();
    exp_ret = '0;
    last_cw = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("first_req", imem_req_valid, 1);
  endtask

  task automatic run_instr(input logic [31:0] instr,
                           input logic [3:0]  ty,
                           input logic        exp_rf,
                           input int          rdy_dly,
                           input int          rsp_dly,
                           input int          exp_lat);
    int   n;
    int   lat;
    int   held;
    exp_t e;
    wait_fetch();
    lat = 0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    lat++;
    e.cw  = mk_cw(instr, ty);
    e.rf  = exp_rf;
    e.ret = exp_ret;
    sb.push_back(e);
    last_cw = e.cw;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr;
    step();
    imem_rsp_valid = 1'b0;
    lat++;
    if (ty == IT_LOAD || ty == IT_STORE) begin
      step();
      lat++;
      held = 0;
      for (int k = 0; k <= rdy_dly; k++) begin
        if (dmem_req_valid) held++;
        dmem_req_ready = (k == rdy_dly);
        step();
        lat++;
      end
      dmem_req_ready = 1'b0;
      chk("dreq_held", held, rdy_dly + 1);
      if (ty == IT_LOAD) begin
        for (int k = 0; k < rsp_dly; k++) begin
          if (k == 0) chk("waitd_dreq", dmem_req_valid, 0);
          dmem_rsp_valid = (k == rsp_dly - 1);
          step();
          lat++;
        end
        dmem_rsp_valid = 1'b0;
      end
    end
    n = 0;
    while (!pc_we && n < 20) begin
      step();
      n++;
      lat++;
    end
    chk("pc_we_seen", pc_we, 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    exp_ret++;
    step();
    chk("pc_we_1cyc", pc_we, 0);
    chk("rf_we_1cyc", rf_we, 0);
    chk("instret", instret, exp_ret);
  endtask

  // Retirement monitor: pops one expectation per pc_we pulse.
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pc_we) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wb_cword", cword, e.cw);
          chk("wb_rf_we", rf_we, e.rf);
          chk("wb_instret", instret, e.ret);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    do_reset();

    run_instr(32'h00500093, IT_IMM,    1'b1, 0, 0, 3);
    run_instr(32'h0000A103, IT_LOAD,   1'b1, 3, 2, 0);
    run_instr(32'h0020A023, IT_STORE,  1'b0, 0, 0, 4);
    run_instr(32'h00000463, IT_BRANCH, 1'b0, 0, 0, 3);
    run_instr(32'h0040A183, IT_LOAD,   1'b1, 0, 1, 5);
    run_instr(32'h002081B3, IT_REG,    1'b1, 0, 0, 3);
    run_instr(32'h00000037, IT_LUI,    1'b0, 0, 0, 3);
    run_instr(32'h008000EF, IT_JAL,    1'b1, 0, 0, 3);

    wait_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00000000;
    step();
    imem_rsp_valid = 1'b0;
    step();
    chk("illegal", illegal, 1);
    chk("ill_cword", cword, last_cw);
    chk("ill_timeout", timeout, 0);
    n = 0;
    repeat (20) begin
      if (pc_we || rf_we || imem_req_valid || dmem_req_valid) n++;
      step();
    end
    chk("halt_quiet", n, 0);
    chk("halt_instret", instret, exp_ret);

    do_reset();
    run_instr(32'h00500093, IT_IMM, 1'b1, 0, 0, 3);

    wait_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    n = 0;
    while (!timeout && n < 300) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_flag", timeout, 1);
    chk("tmo_ireq", imem_req_valid, 0);
    chk("tmo_illegal", illegal, 0);

    do_reset();
    wait_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000A103;
    step();
    imem_rsp_valid = 1'b0;
    step();
    chk("mem_dreq", dmem_req_valid, 1);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("waitd_dreq_low", dmem_req_valid, 0);
    chk("waitd_cword", cword, mk_cw(32'h0000A103, IT_LOAD));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cword", cword, 0);
    chk("arst_ireq", imem_req_valid, 0);
    chk("arst_dreq", dmem_req_valid, 0);
    chk("arst_pcwe", pc_we, 0);
    chk("arst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_fetch", imem_req_valid, 1);
    chk("arst_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
